// File: rtl/whack_game_if.sv
// Game-controller bus: button/generator inputs toward the controller and
// generator-control, score and timer outputs back toward generator and display.
interface whack_game_if #(
  parameter int unsigned TIMER_W = 24,
  parameter int unsigned SCORE_W = 8
);
  logic               i_start;
  logic [4:0]         i_btn_pulse;
  logic [2:0]         i_mole_position;
  logic               i_position_changed;
  logic               o_restart_game;
  logic               o_change_position;
  logic               o_game_over;
  logic [SCORE_W-1:0] o_score;
  logic [3:0]         o_misses;
  logic [TIMER_W-1:0] o_time_left;
  logic [1:0]         o_state;

  // Upstream side: debouncers, mole generator and their consumers.
  modport master (
    output i_start, i_btn_pulse, i_mole_position, i_position_changed,
    input  o_restart_game, o_change_position, o_game_over,
           o_score, o_misses, o_time_left, o_state
  );

  // Controller side.
  modport slave (
    input  i_start, i_btn_pulse, i_mole_position, i_position_changed,
    output o_restart_game, o_change_position, o_game_over,
           o_score, o_misses, o_time_left, o_state
  );
endinterface

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: drives the mole generator, judges presses,
// keeps score/misses and runs the game timer.
module whack_game_ctrl #(
  parameter int unsigned GAME_CYCLES = 300000,
  parameter int unsigned TIMER_W     = 24,
  parameter int unsigned MAX_MISSES  = 5,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  whack_game_if.slave  io_game
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    PLAY    = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] TIME_INIT = TIMER_W'(GAME_CYCLES);
  localparam logic [3:0]         MISS_MAX  = 4'(MAX_MISSES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             r_state;
  logic [SCORE_W-1:0] r_score;
  logic [3:0]         r_misses;
  logic [TIMER_W-1:0] r_time_left;
  logic               r_armed;
  logic               r_req_pending;
  logic               r_restart_game;
  logic               r_change_position;
  logic               r_game_over;

  state_t             w_state_nxt;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [3:0]         w_misses_nxt;
  logic [TIMER_W-1:0] w_time_left_nxt;
  logic               w_armed_nxt;
  logic               w_req_pending_nxt;
  logic               w_restart_game_nxt;
  logic               w_change_position_nxt;
  logic               w_game_over_nxt;

  logic [4:0]         w_target;
  logic               w_judge;
  logic               w_hit;
  logic               w_miss;
  logic               w_escape;
  logic               w_mole_valid;

  // A hole number of 5..7 shifts the one-hot target to zero, so no press can match it.
  assign w_target     = 5'b00001 << io_game.i_mole_position;
  assign w_mole_valid = (io_game.i_mole_position <= 3'd4);
  assign w_judge      = (io_game.i_btn_pulse != 5'b00000) && r_armed && !io_game.i_position_changed;
  assign w_hit        = w_judge && (io_game.i_btn_pulse == w_target);
  assign w_miss       = w_judge && !w_hit;
  assign w_escape     = io_game.i_position_changed && r_armed && !r_req_pending;

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state           <= IDLE;
      r_score           <= '0;
      r_misses          <= '0;
      r_time_left       <= TIME_INIT;
      r_armed           <= 1'b0;
      r_req_pending     <= 1'b0;
      r_restart_game    <= 1'b0;
      r_change_position <= 1'b0;
      r_game_over       <= 1'b1;
    end else begin
      r_state           <= w_state_nxt;
      r_score           <= w_score_nxt;
      r_misses          <= w_misses_nxt;
      r_time_left       <= w_time_left_nxt;
      r_armed           <= w_armed_nxt;
      r_req_pending     <= w_req_pending_nxt;
      r_restart_game    <= w_restart_game_nxt;
      r_change_position <= w_change_position_nxt;
      r_game_over       <= w_game_over_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_score_nxt       = r_score;
    w_misses_nxt      = r_misses;
    w_time_left_nxt   = r_time_left;
    w_armed_nxt       = r_armed;
    w_req_pending_nxt = r_req_pending;

    case (r_state)
      IDLE: begin
        if (io_game.i_start) w_state_nxt = RESTART;
      end
      RESTART: begin
        w_state_nxt = PLAY;
      end
      PLAY: begin
        w_time_left_nxt = r_time_left - TIMER_W'(1);
        if (io_game.i_position_changed) begin
          w_req_pending_nxt = 1'b0;
          w_armed_nxt       = w_mole_valid;
        end else if (w_hit) begin
          w_armed_nxt       = 1'b0;
          w_req_pending_nxt = 1'b1;
          if (r_score != SCORE_MAX) w_score_nxt = r_score + SCORE_W'(1);
        end
        // An escape and a wrong press can never coincide, but one increment covers both anyway.
        if ((w_escape || w_miss) && (r_misses < MISS_MAX)) w_misses_nxt = r_misses + 4'd1;
        if (r_time_left <= TIMER_W'(1)) begin
          w_time_left_nxt = '0;
          w_state_nxt     = OVER;
        end else if (w_misses_nxt >= MISS_MAX) begin
          w_state_nxt = OVER;
        end
      end
      OVER: begin
        if (io_game.i_start) w_state_nxt = RESTART;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Entering RESTART starts a fresh game, so the restart cycle already shows cleared values.
    if (w_state_nxt == RESTART) begin
      w_score_nxt       = '0;
      w_misses_nxt      = '0;
      w_time_left_nxt   = TIME_INIT;
      w_armed_nxt       = 1'b0;
      w_req_pending_nxt = 1'b0;
    end

    w_restart_game_nxt    = (w_state_nxt == RESTART);
    w_game_over_nxt       = (w_state_nxt == IDLE) || (w_state_nxt == OVER);
    w_change_position_nxt = w_hit && (r_state == PLAY) && (w_state_nxt == PLAY);
  end

  assign io_game.o_restart_game    = r_restart_game;
  assign io_game.o_change_position = r_change_position;
  assign io_game.o_game_over       = r_game_over;
  assign io_game.o_score           = r_score;
  assign io_game.o_misses          = r_misses;
  assign io_game.o_time_left       = r_time_left;
  assign io_game.o_state           = r_state;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl: per-cycle vector table through a scoreboard queue,
// plus timer-expiry and asynchronous-reset sequences.
module tb_whack_game_ctrl;

  localparam int unsigned G  = 1000;
  localparam int unsigned TW = 24;
  localparam int unsigned SW = 8;
  localparam int unsigned MM = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  whack_game_if #(.TIMER_W(TW), .SCORE_W(SW)) gif ();

  whack_game_ctrl #(
    .GAME_CYCLES(G), .TIMER_W(TW), .MAX_MISSES(MM), .SCORE_W(SW)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_game(gif.slave)
  );

  typedef struct {
    logic       start;
    logic [4:0] btn;
    logic [2:0] pos;
    logic       pc;
    logic [1:0] st;
    logic [7:0] score;
    logic [3:0] miss;
    logic       rs;
    logic       chg;
    logic       ov;
  } vec_t;

  vec_t tbl[18];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic start, logic [4:0] btn, logic [2:0] pos, logic pc,
                              logic [1:0] st, logic [7:0] score, logic [3:0] miss,
                              logic rs, logic chg, logic ov);
    vec_t v;
    v.start = start; v.btn = btn; v.pos = pos; v.pc = pc;
    v.st = st; v.score = score; v.miss = miss; v.rs = rs; v.chg = chg; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic start, input logic [4:0] btn, input logic [2:0] pos, input logic pc);
    @(negedge clk);
    gif.i_start            = start;
    gif.i_btn_pulse        = btn;
    gif.i_mole_position    = pos;
    gif.i_position_changed = pc;
  endtask

  task automatic step(input logic start, input logic [4:0] btn, input logic [2:0] pos, input logic pc);
    drive(start, btn, pos, pc);
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    drive(v.start, v.btn, v.pos, v.pc);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d_state", idx),   32'(gif.o_state),           32'(e.st));
    chk($sformatf("v%0d_score", idx),   32'(gif.o_score),           32'(e.score));
    chk($sformatf("v%0d_misses", idx),  32'(gif.o_misses),          32'(e.miss));
    chk($sformatf("v%0d_restart", idx), 32'(gif.o_restart_game),    32'(e.rs));
    chk($sformatf("v%0d_change", idx),  32'(gif.o_change_position), 32'(e.chg));
    chk($sformatf("v%0d_over", idx),    32'(gif.o_game_over),       32'(e.ov));
  endtask

  initial begin
    int n;
    //          start btn       pos pc  st score miss rs chg ov
    tbl[0]  = mk(1, 5'b00000, 3'd7, 0, 1, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 5'b00000, 3'd7, 0, 2, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 5'b00000, 3'd3, 1, 2, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 5'b01000, 3'd3, 0, 2, 1, 0, 0, 1, 0);
    tbl[4]  = mk(1, 5'b00000, 3'd3, 0, 2, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 5'b00100, 3'd2, 1, 2, 1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 5'b00001, 3'd2, 0, 2, 1, 1, 0, 0, 0);
    tbl[7]  = mk(0, 5'b00110, 3'd2, 0, 2, 1, 2, 0, 0, 0);
    tbl[8]  = mk(0, 5'b00100, 3'd2, 0, 2, 2, 2, 0, 1, 0);
    tbl[9]  = mk(0, 5'b00100, 3'd2, 0, 2, 2, 2, 0, 0, 0);
    tbl[10] = mk(0, 5'b00000, 3'd7, 1, 2, 2, 2, 0, 0, 0);
    tbl[11] = mk(0, 5'b00000, 3'd4, 1, 2, 2, 2, 0, 0, 0);
    tbl[12] = mk(0, 5'b00000, 3'd0, 1, 2, 2, 3, 0, 0, 0);
    tbl[13] = mk(0, 5'b00010, 3'd0, 0, 2, 2, 4, 0, 0, 0);
    tbl[14] = mk(0, 5'b00000, 3'd1, 1, 3, 2, 5, 0, 0, 1);
    tbl[15] = mk(0, 5'b00010, 3'd1, 0, 3, 2, 5, 0, 0, 1);
    tbl[16] = mk(1, 5'b00000, 3'd1, 0, 1, 0, 0, 1, 0, 0);
    tbl[17] = mk(0, 5'b00000, 3'd1, 0, 2, 0, 0, 0, 0, 0);

    rst = 1'b1;
    gif.i_start = 1'b0; gif.i_btn_pulse = '0; gif.i_mole_position = 3'd7; gif.i_position_changed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   32'(gif.o_state),           32'd0);
    chk("rst_over",    32'(gif.o_game_over),       32'd1);
    chk("rst_restart", 32'(gif.o_restart_game),    32'd0);
    chk("rst_change",  32'(gif.o_change_position), 32'd0);
    chk("rst_score",   32'(gif.o_score),           32'd0);
    chk("rst_misses",  32'(gif.o_misses),          32'd0);
    chk("rst_time",    32'(gif.o_time_left),       32'(G));
    @(negedge clk);
    rst = 1'b0;
    step(0, 5'b00001, 3'd0, 1);
    chk("idle_hold_state", 32'(gif.o_state), 32'd0);
    chk("idle_hold_score", 32'(gif.o_score), 32'd0);

    // PLAY entered after vector 1; vectors 2..14 are 13 timer decrements, then held in OVER.
    for (int i = 0; i < 18; i++) begin
      apply(tbl[i], i);
      if (i == 15) chk("over_time_held", 32'(gif.o_time_left), 32'(G - 13));
      if (i == 17) chk("play_time_init", 32'(gif.o_time_left), 32'(G));
    end

    // Countdown to expiry, with a hit landing on the final PLAY cycle.
    step(0, 5'b00000, 3'd0, 1);
    chk("cd_first", 32'(gif.o_time_left), 32'(G - 1));
    n = 1;
    while (gif.o_time_left != TW'(1) && n < int'(G) + 10) begin
      step(0, 5'b00000, 3'd0, 0);
      n++;
    end
    chk("cd_cycles", 32'(n), 32'(G - 1));
    chk("cd_state_play", 32'(gif.o_state), 32'd2);
    step(0, 5'b00001, 3'd0, 0);
    chk("exp_state",  32'(gif.o_state),           32'd3);
    chk("exp_time",   32'(gif.o_time_left),       32'd0);
    chk("exp_score",  32'(gif.o_score),           32'd1);
    chk("exp_change", 32'(gif.o_change_position), 32'd0);
    chk("exp_over",   32'(gif.o_game_over),       32'd1);
    step(0, 5'b00000, 3'd0, 0);
    chk("over_time_zero", 32'(gif.o_time_left), 32'd0);
    chk("over_change",    32'(gif.o_change_position), 32'd0);

    // Three hits, then reset asserted asynchronously while o_change_position is high.
    step(1, 5'b00000, 3'd7, 0);
    step(0, 5'b00000, 3'd7, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 5'b00000, 3'(k), 1);
      step(0, 5'(1 << k), 3'(k), 0);
    end
    chk("pre_rst_score",  32'(gif.o_score),           32'd3);
    chk("pre_rst_change", 32'(gif.o_change_position), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_state",   32'(gif.o_state),           32'd0);
    chk("arst_over",    32'(gif.o_game_over),       32'd1);
    chk("arst_score",   32'(gif.o_score),           32'd0);
    chk("arst_time",    32'(gif.o_time_left),       32'(G));
    chk("arst_change",  32'(gif.o_change_position), 32'd0);
    chk("arst_restart", 32'(gif.o_restart_game),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 5'b00000, 3'd7, 0);
    chk("post_rst_state", 32'(gif.o_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/whack_game_ctrl.md
Name: whack_game_ctrl

Overview:
Game-level sequencer for the whack-a-mole design.
- Drives the restart / change-position / game-over controls of the mole position generator.
- Judges debounced button pulses against the current mole position.
- Keeps score and miss count, and runs the game timer.
- Sits between the button debouncers and the mole generator; its score, miss and time outputs feed the display driver.

Parameters:
GAME_CYCLES, 300000, PLAY duration in i_clk cycles (simulation scale; hardware value 3000000000 requires TIMER_W=32)
TIMER_W, 24, width of time-left counter
MAX_MISSES, 5, miss count that ends the game (1..15)
SCORE_W, 8, score width

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle start/restart request
i_btn_pulse  in  5  one-cycle debounced press per hole 0..4
i_mole_position  in  3  current mole hole from generator (0..4 valid, 5+ = no mole)
i_position_changed  in  1  generator's one-cycle "mole moved" strobe
o_restart_game  out  1  one-cycle restart pulse to generator
o_change_position  out  1  one-cycle request for a new mole position
o_game_over  out  1  freezes generator; high in IDLE and OVER
o_score  out  SCORE_W  hits this game
o_misses  out  4  misses this game
o_time_left  out  TIMER_W  cycles remaining in PLAY
o_state  out  2  IDLE=0, RESTART=1, PLAY=2, OVER=3

Behaviour:
- Reset (async): state IDLE, o_game_over=1, o_restart_game=0, o_change_position=0, o_score=0, o_misses=0, o_time_left=GAME_CYCLES. Internal flags armed=0, req_pending=0. Reset mid-game aborts immediately; no pulses are emitted.
- IDLE, i_start=1 -> RESTART.
- RESTART: lasts exactly one cycle.
  - o_restart_game=1 and o_game_over=0 (both registered outputs).
  - Clears score, misses, armed and req_pending; loads o_time_left=GAME_CYCLES.
  - Next state: PLAY.
- PLAY:
  - o_game_over=0.
  - o_time_left decrements by 1 each cycle.
  - When o_time_left==1 and is decrementing, the next state is OVER, with o_time_left=0.
  - i_start is ignored.
- On i_position_changed=1 in PLAY:
  - If req_pending=1, clear it (requested move).
  - Otherwise, if armed=1, the mole escaped: misses+1.
  - In both cases set armed=1 if i_mole_position<=4, else armed=0.
- Press judging in PLAY applies only when i_btn_pulse!=0, armed=1 and i_position_changed=0:
  - Exactly one bit set and it matches i_mole_position: hit. Score+1, saturating at all-ones. armed=0, req_pending=1. o_change_position=1 on the next cycle, for one cycle.
  - Any other nonzero pattern, including multiple bits: one miss only.
- Presses are ignored (no hit, no miss) in these cases:
  - armed=0 (including while req_pending=1 awaiting the move);
  - any cycle where i_position_changed=1;
  - outside PLAY.
- Miss and escape in the same cycle: misses increments by 1 only.
- o_misses saturates at MAX_MISSES. When it reaches MAX_MISSES, the next state is OVER.
- Timer expiry takes priority over a hit in the same cycle: the score still updates, but no o_change_position is issued.
- OVER:
  - o_game_over=1; score, misses and time are held; o_change_position=0.
  - i_start=1 -> RESTART.
- Pulse latency: o_restart_game rises one cycle after i_start is sampled. o_change_position rises one cycle after the hit press is sampled.

Test Plan:
- Reset asserted mid-PLAY (score=3) -> same cycle: state=0, o_game_over=1, o_score=0, o_time_left=300000, no pulses.
- i_start in IDLE -> o_restart_game high exactly 1 cycle, then state=2; o_time_left counts 300000 down to 0 over 300000 cycles, then state=3 and o_game_over=1.
- Generator strobes position 3; i_btn_pulse=5'b01000 -> o_score=1, o_change_position=1 one cycle later for one cycle; following i_position_changed causes no miss.
- Mole at 2; press 5'b00001, then 5'b00110 -> o_misses=1 then 2; o_score unchanged.
- Two unrequested i_position_changed strobes with no press -> second strobe gives o_misses=1; five such escapes -> o_misses=5, state=3 next cycle.
- Press with i_position_changed=1 in the same cycle -> no score/miss change; i_start in PLAY -> ignored; i_start in OVER -> RESTART, score cleared.
